wb_decode_mux: RTL and testbench

WB_DECODE_MUX -- requirements
Module: wb_decode_mux

---
 rtl/wb_intercon_pkg.sv | 21 ++
 rtl/wb_decode_mux.sv | 182 ++++++++++++++++++
 tb/tb_wb_decode_mux.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone interconnect blocks: decoder FSM states
// and the width helpers used to size the selected index and the watchdog counter.
package wb_intercon_pkg;

   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,
      WB_ACTIVE = 2'd1,
      WB_DECERR = 2'd2,
      WB_ABORT  = 2'd3
   } wb_dec_state_t;

   // Width of a counter that must hold 0..limit; a disabled watchdog still gets one bit.
   function automatic int wb_cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

   function automatic int wb_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_decode_mux.sv
// Wishbone 1-to-N address decoder with registered slave select, response
// multiplexer and a per-transfer watchdog that aborts a stalled slave.
//
// state  | meaning
// IDLE   | no cycle open; decode wbm_adr_i when the master raises cyc&stb
// ACTIVE | cycle routed to the registered slave; watchdog counting stalls
// DECERR | no slave matched; one-cycle error to the master
// ABORT  | cycle dead; everything quiet until the master drops cyc
module wb_decode_mux
   import wb_intercon_pkg::*;
#(
   parameter int                      dw         = 32,
   parameter int                      aw         = 32,
   parameter int                      num_slaves = 2,
   parameter logic [num_slaves*aw-1:0] match_addr = '0,
   parameter logic [num_slaves*aw-1:0] match_mask = '0,
   parameter int                      timeout    = 255
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,

   input  logic [aw-1:0]            wbm_adr_i,
   input  logic [dw-1:0]            wbm_dat_i,
   input  logic [3:0]               wbm_sel_i,
   input  logic                     wbm_we_i,
   input  logic                     wbm_cyc_i,
   input  logic                     wbm_stb_i,
   input  logic [2:0]               wbm_cti_i,
   input  logic [1:0]               wbm_bte_i,
   output logic [dw-1:0]            wbm_dat_o,
   output logic                     wbm_ack_o,
   output logic                     wbm_err_o,
   output logic                     wbm_rty_o,

   output logic [num_slaves*aw-1:0] wbs_adr_o,
   output logic [num_slaves*dw-1:0] wbs_dat_o,
   output logic [num_slaves*4-1:0]  wbs_sel_o,
   output logic [num_slaves-1:0]    wbs_we_o,
   output logic [num_slaves-1:0]    wbs_cyc_o,
   output logic [num_slaves-1:0]    wbs_stb_o,
   output logic [num_slaves*3-1:0]  wbs_cti_o,
   output logic [num_slaves*2-1:0]  wbs_bte_o,
   input  logic [num_slaves*dw-1:0] wbs_dat_i,
   input  logic [num_slaves-1:0]    wbs_ack_i,
   input  logic [num_slaves-1:0]    wbs_err_i,
   input  logic [num_slaves-1:0]    wbs_rty_i
);

   localparam int               idx_w    = wb_idx_width(num_slaves);
   localparam int               cnt_w    = wb_cnt_width(timeout);
   localparam logic             wd_en    = (timeout > 0);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'((timeout > 0) ? timeout - 1 : 0);

   wb_dec_state_t    state_q, state_d;
   logic [idx_w-1:0] sel_q, sel_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;

   logic             dec_hit;
   logic [idx_w-1:0] dec_idx;
   logic [num_slaves-1:0] sel_oh;
   logic [dw-1:0]    sel_dat;
   logic             sel_ack, sel_err, sel_rty, sel_resp;
   logic             timeout_hit;

   // Request fields go to every port untouched; only cyc/stb steer the cycle.
   assign wbs_adr_o = {num_slaves{wbm_adr_i}};
   assign wbs_dat_o = {num_slaves{wbm_dat_i}};
   assign wbs_sel_o = {num_slaves{wbm_sel_i}};
   assign wbs_we_o  = {num_slaves{wbm_we_i}};
   assign wbs_cti_o = {num_slaves{wbm_cti_i}};
   assign wbs_bte_o = {num_slaves{wbm_bte_i}};

   // Scan from the top down so the lowest matching index is the one kept.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = num_slaves - 1; i >= 0; i--) begin
         if ((wbm_adr_i & match_mask[i*aw +: aw]) ==
             (match_addr[i*aw +: aw] & match_mask[i*aw +: aw])) begin
            dec_hit = 1'b1;
            dec_idx = idx_w'(i);
         end
      end
   end

   always_comb begin
      sel_oh  = '0;
      sel_dat = '0;
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_rty = 1'b0;
      for (int i = 0; i < num_slaves; i++) begin
         if (idx_w'(i) == sel_q) begin
            sel_oh[i] = 1'b1;
            sel_dat   = wbs_dat_i[i*dw +: dw];
            sel_ack   = wbs_ack_i[i];
            sel_err   = wbs_err_i[i];
            sel_rty   = wbs_rty_i[i];
         end
      end
   end

   assign sel_resp  = sel_ack | sel_err | sel_rty;
   assign wbm_dat_o = sel_dat;

   // A response arriving on the limit cycle masks the timeout.
   assign timeout_hit = wd_en && (state_q == WB_ACTIVE) && wbm_cyc_i && wbm_stb_i &&
                        !sel_resp && (cnt_q == cnt_last);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      wbs_cyc_o = '0;
      wbs_stb_o = '0;
      wbm_ack_o = 1'b0;
      wbm_err_o = 1'b0;
      wbm_rty_o = 1'b0;

      case (state_q)
         WB_IDLE: begin
            if (wbm_cyc_i && wbm_stb_i) begin
               if (dec_hit) begin
                  state_d = WB_ACTIVE;
                  sel_d   = dec_idx;
               end else begin
                  state_d = WB_DECERR;
               end
            end
         end

         WB_ACTIVE: begin
            wbs_cyc_o = sel_oh & {num_slaves{wbm_cyc_i}};
            wbs_stb_o = sel_oh & {num_slaves{wbm_stb_i}};
            wbm_ack_o = sel_ack;
            wbm_rty_o = sel_rty;
            wbm_err_o = sel_err | timeout_hit;
            if (sel_resp) begin
               cnt_d = '0;
            end else if (wd_en && wbm_stb_i) begin
               cnt_d = cnt_q + cnt_w'(1);
            end
            if (timeout_hit) begin
               state_d = WB_ABORT;
            end
         end

         WB_DECERR: begin
            wbm_err_o = 1'b1;
            state_d   = WB_ABORT;
         end

         WB_ABORT: begin
            state_d = WB_ABORT;
         end

         default: begin
            state_d = WB_IDLE;
         end
      endcase

      if (!wbm_cyc_i) begin
         state_d = WB_IDLE;
      end
      if (state_d != WB_ACTIVE) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= WB_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_decode_mux.sv
// Directed bench for wb_decode_mux: two slaves split on the top address nibble,
// watchdog limit of four stalled strobe cycles.
module tb_wb_decode_mux;

   localparam int dw = 32;
   localparam int aw = 32;
   localparam int ns = 2;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic [aw-1:0] wbm_adr_i;
   logic [dw-1:0] wbm_dat_i;
   logic [3:0]    wbm_sel_i;
   logic          wbm_we_i, wbm_cyc_i, wbm_stb_i;
   logic [2:0]    wbm_cti_i;
   logic [1:0]    wbm_bte_i;
   logic [dw-1:0] wbm_dat_o;
   logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [ns*aw-1:0] wbs_adr_o;
   logic [ns*dw-1:0] wbs_dat_o;
   logic [ns*4-1:0]  wbs_sel_o;
   logic [ns-1:0]    wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [ns*3-1:0]  wbs_cti_o;
   logic [ns*2-1:0]  wbs_bte_o;
   logic [ns*dw-1:0] wbs_dat_i;
   logic [ns-1:0]    wbs_ack_i, wbs_err_i, wbs_rty_i;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_d;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_decode_mux #(
      .dw(dw), .aw(aw), .num_slaves(ns),
      .match_addr({32'h1000_0000, 32'h0000_0000}),
      .match_mask({32'hF000_0000, 32'hF000_0000}),
      .timeout(4)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
      .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
      .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
      .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
      .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
      .wbs_rty_i(wbs_rty_i)
   );

   task automatic drop_cycle();
      @(negedge wb_clk_i);
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      wbm_cti_i = 3'b000;
      wbs_ack_i = '0;
      @(negedge wb_clk_i);
   endtask

   task automatic test_reset();
      wb_rst_i  = 1'b1;
      wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = 4'hF; wbm_we_i = 1'b0;
      wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = '0; wbm_bte_i = '0;
      wbs_dat_i = '0; wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;
      repeat (2) @(negedge wb_clk_i);
      wbm_adr_i = 32'h1000_0000;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      wbs_ack_i = 2'b11;
      #1;
      checks++;
      if ({wbs_cyc_o, wbs_stb_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_cyc_stb got=%b expected=0000", {wbs_cyc_o, wbs_stb_o});
      end
      checks++;
      if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_resp got=%b expected=000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
      end
      @(negedge wb_clk_i);
      wb_rst_i  = 1'b0;
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      wbs_ack_i = '0;
      @(negedge wb_clk_i);
   endtask

   task automatic test_read_slave1();
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h1000_0004;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      #1;
      checks++;
      if (wbs_cyc_o !== 2'b00) begin
         failures++;
         $display("FAIL rd_decode_latency got=%b expected=00", wbs_cyc_o);
      end
      @(negedge wb_clk_i);
      wbs_dat_i = {32'hCAFE_0001, 32'h5555_0000};
      wbs_ack_i = 2'b10;
      exp_q.push_back(32'hCAFE_0001);
      #1;
      checks++;
      if ({wbs_cyc_o, wbs_stb_o} !== 4'b1010) begin
         failures++;
         $display("FAIL rd_slave1_cyc_stb got=%b expected=1010", {wbs_cyc_o, wbs_stb_o});
      end
      checks++;
      if (wbs_adr_o !== {2{32'h1000_0004}}) begin
         failures++;
         $display("FAIL rd_adr_broadcast got=%h expected=%h", wbs_adr_o, {2{32'h1000_0004}});
      end
      checks++;
      if (wbm_ack_o !== 1'b1) begin
         failures++;
         $display("FAIL rd_ack got=%b expected=1", wbm_ack_o);
      end
      if (wbm_ack_o === 1'b1 && exp_q.size() > 0) begin
         exp_d = exp_q.pop_front();
         checks++;
         if (wbm_dat_o !== exp_d) begin
            failures++;
            $display("FAIL rd_data got=%h expected=%h", wbm_dat_o, exp_d);
         end
      end
      @(negedge wb_clk_i);
      wbs_ack_i = '0;
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      #1;
      checks++;
      if (wbs_cyc_o !== 2'b00) begin
         failures++;
         $display("FAIL rd_cyc_drop_same_cycle got=%b expected=00", wbs_cyc_o);
      end
      @(negedge wb_clk_i);
   endtask

   task automatic test_decerr();
      logic [3:0] err_pat;
      logic [1:0] cyc_seen;
      err_pat  = '0;
      cyc_seen = '0;
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h3000_0000;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      #1;
      cyc_seen = cyc_seen | wbs_cyc_o;
      for (int k = 0; k < 4; k++) begin
         @(negedge wb_clk_i);
         if (k == 3) begin
            wbm_cyc_i = 1'b0;
            wbm_stb_i = 1'b0;
         end
         #1;
         err_pat[k] = wbm_err_o;
         cyc_seen   = cyc_seen | wbs_cyc_o;
      end
      checks++;
      if (err_pat !== 4'b0001) begin
         failures++;
         $display("FAIL decerr_err_pulse got=%b expected=0001", err_pat);
      end
      checks++;
      if (cyc_seen !== 2'b00) begin
         failures++;
         $display("FAIL decerr_no_slave_cyc got=%b expected=00", cyc_seen);
      end
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h0000_0010;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      @(negedge wb_clk_i);
      #1;
      checks++;
      if (wbs_cyc_o !== 2'b01) begin
         failures++;
         $display("FAIL decerr_back_to_idle got=%b expected=01", wbs_cyc_o);
      end
      drop_cycle();
   endtask

   task automatic test_timeout();
      logic [3:0] err_pat;
      logic       cyc_bad;
      logic       quiet_bad;
      err_pat   = '0;
      cyc_bad   = 1'b0;
      quiet_bad = 1'b0;
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h0000_0100;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      wbs_ack_i = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge wb_clk_i);
         #1;
         err_pat[k] = wbm_err_o;
         if (wbs_cyc_o !== 2'b01) cyc_bad = 1'b1;
      end
      checks++;
      if (err_pat !== 4'b1000) begin
         failures++;
         $display("FAIL timeout_err_on_stb4 got=%b expected=1000", err_pat);
      end
      checks++;
      if (cyc_bad !== 1'b0) begin
         failures++;
         $display("FAIL timeout_cyc_held got=%b expected=0", cyc_bad);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge wb_clk_i);
         #1;
         if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 7'b0) quiet_bad = 1'b1;
      end
      checks++;
      if (quiet_bad !== 1'b0) begin
         failures++;
         $display("FAIL timeout_abort_quiet got=%b expected=0", quiet_bad);
      end
      drop_cycle();
   endtask

   task automatic test_timeout_race();
      logic [3:0] err_pat;
      logic [2:0] err_pat2;
      logic       cyc_bad;
      err_pat  = '0;
      err_pat2 = '0;
      cyc_bad  = 1'b0;
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h0000_0200;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge wb_clk_i);
         if (k == 3) begin
            wbs_dat_i = {32'h7777_7777, 32'hA5A5_0004};
            wbs_ack_i = 2'b01;
            exp_q.push_back(32'hA5A5_0004);
         end
         #1;
         err_pat[k] = wbm_err_o;
      end
      checks++;
      if (wbm_ack_o !== 1'b1) begin
         failures++;
         $display("FAIL race_ack got=%b expected=1", wbm_ack_o);
      end
      if (wbm_ack_o === 1'b1 && exp_q.size() > 0) begin
         exp_d = exp_q.pop_front();
         checks++;
         if (wbm_dat_o !== exp_d) begin
            failures++;
            $display("FAIL race_data got=%h expected=%h", wbm_dat_o, exp_d);
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge wb_clk_i);
         wbs_ack_i = '0;
         #1;
         err_pat2[k] = wbm_err_o;
         if (wbs_cyc_o !== 2'b01) cyc_bad = 1'b1;
      end
      checks++;
      if ({err_pat, err_pat2} !== 7'b0) begin
         failures++;
         $display("FAIL race_no_err got=%b expected=0000000", {err_pat, err_pat2});
      end
      checks++;
      if (cyc_bad !== 1'b0) begin
         failures++;
         $display("FAIL race_counter_cleared got=%b expected=0", cyc_bad);
      end
      drop_cycle();
   endtask

   task automatic test_burst();
      logic [31:0] adr;
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h0FFF_FFF8;
      wbm_cti_i = 3'b010;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge wb_clk_i);
         adr       = 32'h0FFF_FFF8 + 32'(4 * b);
         wbm_adr_i = adr;
         wbm_cti_i = (b == 3) ? 3'b111 : 3'b010;
         wbs_dat_i = {32'hBAD0_0000 + 32'(b), 32'hD000_0000 + 32'(b)};
         wbs_ack_i = 2'b11;
         exp_q.push_back(32'hD000_0000 + 32'(b));
         #1;
         checks++;
         if (wbs_cyc_o !== 2'b01) begin
            failures++;
            $display("FAIL burst_cyc beat=%0d got=%b expected=01", b, wbs_cyc_o);
         end
         checks++;
         if (wbs_adr_o[aw +: aw] !== adr) begin
            failures++;
            $display("FAIL burst_adr beat=%0d got=%h expected=%h", b, wbs_adr_o[aw +: aw], adr);
         end
         if (wbm_ack_o === 1'b1 && exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (wbm_dat_o !== exp_d) begin
               failures++;
               $display("FAIL burst_data beat=%0d got=%h expected=%h", b, wbm_dat_o, exp_d);
            end
         end else begin
            checks++;
            failures++;
            $display("FAIL burst_ack beat=%0d got=%b expected=1", b, wbm_ack_o);
         end
      end
      drop_cycle();
   endtask

   task automatic test_reset_active();
      @(negedge wb_clk_i);
      wbm_adr_i = 32'h1000_0000;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      @(negedge wb_clk_i);
      #1;
      checks++;
      if (wbs_cyc_o !== 2'b10) begin
         failures++;
         $display("FAIL rst_pre_active got=%b expected=10", wbs_cyc_o);
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i  = 1'b0;
      wbs_ack_i = 2'b10;
      #1;
      checks++;
      if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 7'b0) begin
         failures++;
         $display("FAIL rst_abandon got=%b expected=0000000",
                  {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o});
      end
      @(negedge wb_clk_i);
      wbs_ack_i = '0;
      #1;
      checks++;
      if (wbs_cyc_o !== 2'b10) begin
         failures++;
         $display("FAIL rst_redecode_from_idle got=%b expected=10", wbs_cyc_o);
      end
      drop_cycle();
   endtask

   initial begin
      test_reset();
      test_read_slave1();
      test_decerr();
      test_timeout();
      test_timeout_race();
      test_burst();
      test_reset_active();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drained got=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
